logic_unit_pipe: RTL and testbench

//   Parametrised, registered multi-function bitwise logic unit; next generation of our single-bit AND/OR/NOT gates.

---
 rtl/logic_unit_pkg.sv | 18 +
 rtl/logic_unit_core.sv | 49 ++++
 rtl/logic_unit_pipe.sv | 92 +++++++++
 tb/tb_logic_unit_pipe.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared opcode encoding and result-layout constants for the pipelined logic unit.
package logic_unit_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned FLAG_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_t;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational op evaluation plus zero/all-ones/parity flags.
// The result is packed as {data, zero, ones, parity}.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  op_t                     op,
  input  logic [WIDTH-1:0]        x,
  input  logic [WIDTH-1:0]        y,
  output logic [WIDTH+FLAG_W-1:0] result_c
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             ones;
    logic             parity;
  } res_t;

  logic [WIDTH-1:0] data;
  res_t             res;

  always_comb begin
    data = x;
    case (op)
      OP_AND:  data = x & y;
      OP_OR:   data = x | y;
      OP_NOT:  data = ~x;
      OP_NAND: data = ~(x & y);
      OP_NOR:  data = ~(x | y);
      OP_XOR:  data = x ^ y;
      OP_XNOR: data = ~(x ^ y);
      OP_PASS: data = x;
      default: data = x;
    endcase
  end

  always_comb begin
    res        = '0;
    res.data   = data;
    res.zero   = (data == '0);
    res.ones   = &data;
    res.parity = ^data;
  end

  assign result_c = res;

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit with a valid/ready input, a one-entry skid buffer
// and optional chaining of the last accepted result into the y operand.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHAIN_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_chain,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             ones;
    logic             parity;
  } res_t;

  localparam res_t RES_RST = '{data: '0, zero: 1'b1, ones: 1'b0, parity: 1'b0};

  res_t             out_r;
  res_t             skid_r;
  res_t             core_res;
  logic             skid_valid;
  logic [WIDTH-1:0] last_result;
  logic [WIDTH-1:0] y_sel;
  logic             acc;
  logic             fire;

  assign y_sel = ((CHAIN_EN != 0) && in_chain) ? last_result : in_y;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .op       (op_t'(in_op)),
    .x        (in_x),
    .y        (y_sel),
    .result_c (core_res)
  );

  // Ready depends only on skid occupancy, so there is no path from out_ready.
  assign in_ready = ~skid_valid;
  assign acc      = in_valid & ~skid_valid;
  assign fire     = out_valid & out_ready;

  // Output stage refills from the skid first to preserve beat order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_r       <= RES_RST;
      skid_valid  <= 1'b0;
      skid_r      <= RES_RST;
      last_result <= '0;
    end else begin
      if (acc) begin
        last_result <= core_res.data;
      end
      if (!out_valid || fire) begin
        if (skid_valid) begin
          out_r      <= skid_r;
          out_valid  <= 1'b1;
          skid_valid <= 1'b0;
        end else if (acc) begin
          out_r     <= core_res;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (acc) begin
        skid_r     <= core_res;
        skid_valid <= 1'b1;
      end
    end
  end

  assign out_data   = out_r.data;
  assign out_zero   = out_r.zero;
  assign out_ones   = out_r.ones;
  assign out_parity = out_r.parity;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe; a second instance built with CHAIN_EN=0
// shares the stimulus so chaining can be compared against plain operation.
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_op;
  logic       in_chain;
  logic [7:0] in_x;
  logic [7:0] in_y;
  logic       out_ready;

  logic       in_ready, out_valid, out_zero, out_ones, out_parity;
  logic [7:0] out_data;
  logic       in_ready_n, out_valid_n, out_zero_n, out_ones_n, out_parity_n;
  logic [7:0] out_data_n;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_last;
  logic [7:0] exp_d;
  logic [7:0] ops_exp [8];
  logic [2:0] r_op;
  logic       r_chain;
  logic [7:0] r_x;
  logic [7:0] r_y;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .CHAIN_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_chain(in_chain), .in_x(in_x), .in_y(in_y), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero),
    .out_ones(out_ones), .out_parity(out_parity)
  );

  logic_unit_pipe #(.WIDTH(8), .CHAIN_EN(0)) dut_nochain (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n), .in_op(in_op),
    .in_chain(in_chain), .in_x(in_x), .in_y(in_y), .out_valid(out_valid_n),
    .out_ready(out_ready), .out_data(out_data_n), .out_zero(out_zero_n),
    .out_ones(out_ones_n), .out_parity(out_parity_n)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [2:0] op, input logic chain, input logic [7:0] x, input logic [7:0] y);
    in_valid = 1'b1;
    in_op    = op;
    in_chain = chain;
    in_x     = x;
    in_y     = y;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~a;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  initial begin
    ops_exp = '{8'h4A, 8'hDF, 8'h35, 8'hB5, 8'h20, 8'h95, 8'h6A, 8'hCA};
    rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_chain = 1'b0;
    in_x = 8'h00; in_y = 8'h00; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", 16'(out_valid), 16'h0);
    check("rst_out_data", 16'(out_data), 16'h00);
    check("rst_flags", 16'({out_zero, out_ones, out_parity}), 16'b100);
    check("rst_in_ready", 16'(in_ready), 16'h1);

    // Async reset with a beat held in the output stage.
    out_ready = 1'b0;
    beat(3'd7, 1'b0, 8'h81, 8'h00);
    tick();
    in_valid = 1'b0;
    check("pre_rst_held", 16'({out_valid, out_data}), 16'h181);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 16'(out_valid), 16'h0);
    check("async_rst_data", 16'(out_data), 16'h00);
    check("async_rst_zero", 16'(out_zero), 16'h1);
    check("async_rst_ready", 16'(in_ready), 16'h1);
    tick();
    rst = 1'b0;

    // Every opcode back to back.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      beat(3'(i), 1'b0, 8'hCA, 8'h5F);
      tick();
      check($sformatf("op%0d", i), 16'({out_valid, out_data}), {7'h0, 1'b1, ops_exp[i]});
      if (i == 0) check("and_flags", 16'({out_zero, out_ones, out_parity}), 16'b001);
    end
    beat(3'd7, 1'b0, 8'hFF, 8'h00);
    tick();
    check("pass_ff_data", 16'(out_data), 16'hFF);
    check("pass_ff_flags", 16'({out_zero, out_ones, out_parity}), 16'b010);
    beat(3'd0, 1'b0, 8'hF0, 8'h0F);
    tick();
    check("and_zero_data", 16'(out_data), 16'h00);
    check("and_zero_flags", 16'({out_zero, out_ones, out_parity}), 16'b100);
    in_valid = 1'b0;
    tick();
    check("drain_valid", 16'(out_valid), 16'h0);

    // Backpressure: two beats held, third waits.
    out_ready = 1'b0;
    beat(3'd0, 1'b0, 8'hCA, 8'h5F);
    tick();
    check("bp1_out", 16'({out_valid, out_data}), 16'h14A);
    check("bp1_ready", 16'(in_ready), 16'h1);
    beat(3'd1, 1'b0, 8'hCA, 8'h5F);
    tick();
    check("bp2_out", 16'({out_valid, out_data}), 16'h14A);
    check("bp2_ready", 16'(in_ready), 16'h0);
    beat(3'd5, 1'b0, 8'hCA, 8'h5F);
    tick();
    check("bp3_stable", 16'({out_valid, out_data, in_ready}), 16'h294);
    out_ready = 1'b1;
    tick();
    check("bp4_out", 16'({out_valid, out_data}), 16'h1DF);
    check("bp4_ready", 16'(in_ready), 16'h1);
    tick();
    check("bp5_out", 16'({out_valid, out_data}), 16'h195);
    in_valid = 1'b0;
    tick();
    check("bp6_valid", 16'(out_valid), 16'h0);

    // Chaining; the CHAIN_EN=0 instance must use in_y instead.
    beat(3'd1, 1'b0, 8'h01, 8'h00);
    tick();
    check("chain0", 16'(out_data), 16'h01);
    beat(3'd1, 1'b1, 8'h02, 8'h10);
    tick();
    check("chain_or", 16'(out_data), 16'h03);
    check("nochain_or", 16'(out_data_n), 16'h12);
    beat(3'd5, 1'b1, 8'hFF, 8'h10);
    tick();
    check("chain_xor", 16'(out_data), 16'hFC);
    check("nochain_xor", 16'(out_data_n), 16'hEF);

    // Streaming with random ops and chaining against the bench model.
    model_last = 8'hFC;
    for (int i = 0; i < 16; i++) begin
      r_op    = 3'($urandom_range(0, 7));
      r_chain = 1'($urandom_range(0, 1));
      r_x     = 8'($urandom);
      r_y     = 8'($urandom);
      beat(r_op, r_chain, r_x, r_y);
      exp_d      = model(r_op, r_x, r_chain ? model_last : r_y);
      model_last = exp_d;
      tick();
      check($sformatf("stream%0d", i), 16'({in_ready, out_valid, out_data}), {6'h0, 2'b11, exp_d});
      check($sformatf("stream%0d_flags", i), 16'({out_zero, out_ones, out_parity}),
            16'({exp_d == 8'h00, exp_d == 8'hFF, ^exp_d}));
    end
    in_valid = 1'b0;
    tick();

    // Reset with the skid full loses both beats and clears the chain value.
    out_ready = 1'b0;
    beat(3'd7, 1'b0, 8'hAA, 8'h00);
    tick();
    beat(3'd7, 1'b0, 8'h55, 8'h00);
    tick();
    in_valid = 1'b0;
    check("skid_full_ready", 16'(in_ready), 16'h0);
    #2 rst = 1'b1;
    #1;
    check("rst_skid_valid", 16'(out_valid), 16'h0);
    check("rst_skid_ready", 16'(in_ready), 16'h1);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post_rst_empty", 16'(out_valid), 16'h0);
    beat(3'd1, 1'b1, 8'h00, 8'hFF);
    tick();
    check("post_rst_chain", 16'({out_valid, out_data, out_zero}), 16'h201);
    check("post_rst_nochain", 16'(out_data_n), 16'hFF);
    in_valid = 1'b0;
    tick();
    check("final_empty", 16'(out_valid), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
